// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: ALU funct codes, forward-select encoding, default widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;

    // ALU function codes (R-type funct field encoding)
    localparam logic [5:0] ALU_AND = 6'h24;
    localparam logic [5:0] ALU_OR  = 6'h25;
    localparam logic [5:0] ALU_ADD = 6'h20;
    localparam logic [5:0] ALU_SUB = 6'h22;
    localparam logic [5:0] ALU_SLT = 6'h2A;
    localparam logic [5:0] ALU_NOR = 6'h27;
    localparam logic [5:0] ALU_SRL = 6'h02;
    localparam logic [5:0] ALU_SLL = 6'h00;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding: picks EX/MEM result, MEM/WB data or the latched register value.
// Latency: purely combinational.
// Backpressure: none; register 0 is never forwarded.
module fwd_mux
    import mips_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic [REG_AW-1:0] reg_addr,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_res,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_data,
    output logic [DATA_W-1:0] fwd_data
);

    fwd_sel_e sel;

    // Priority compare: the younger producer (EX/MEM) wins over MEM/WB
    always_comb begin
        sel = FWD_REG;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == reg_addr)) begin
            sel = FWD_EXMEM;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == reg_addr)) begin
            sel = FWD_MEMWB;
        end
    end

    // 3:1 data select
    always_comb begin
        fwd_data = reg_data;
        case (sel)
            FWD_EXMEM: fwd_data = exmem_res;
            FWD_MEMWB: fwd_data = memwb_data;
            default:   fwd_data = reg_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with forwarding, load-use stall detection and branch flush.
// Latency: one cycle from ID inputs to EX outputs; forwarding is combinational in EX.
// Backpressure: stall_id holds upstream on a load-use hazard while a bubble enters EX.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [5:0]        id_opsel,
    input  logic [4:0]        id_shamt,
    input  logic              id_alu_src,
    input  logic              id_uses_rt,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_reg_write,
    input  logic              flush,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_res,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_data,
    output logic              stall_id,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [5:0]        alu_opsel,
    output logic [4:0]        alu_shamt,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write
);

    logic              valid_q, reg_write_q, mem_read_q, mem_write_q, alu_src_q;
    logic [REG_AW-1:0] rs_addr_q, rt_addr_q, rd_q;
    logic [DATA_W-1:0] rs_data_q, rt_data_q, imm_q;
    logic [5:0]        opsel_q;
    logic [4:0]        shamt_q;

    logic              hazard;
    logic              kill;
    logic [DATA_W-1:0] rs_cap, rt_cap;
    logic [DATA_W-1:0] rs_fwd, rt_fwd;

    // Load-use hazard against the load currently in EX; bubble on hazard or flush
    always_comb begin
        hazard = valid_q && mem_read_q && (rd_q != '0) && id_valid &&
                 ((rd_q == id_rs_addr) || (id_uses_rt && (rd_q == id_rt_addr)));
        kill     = flush || hazard;
        stall_id = hazard && rst_n;
    end

    // Write-through: a register being written back this cycle is fresher than the RF read
    always_comb begin
        rs_cap = id_rs_data;
        rt_cap = id_rt_data;
        if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_rs_addr)) rs_cap = memwb_data;
        if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_rt_addr)) rt_cap = memwb_data;
    end

    // Pipeline register: reset and bubbles clear everything, giving SLL $0 (NOP)
    always_ff @(posedge clk) begin
        if (!rst_n || kill) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            alu_src_q   <= 1'b0;
            rs_addr_q   <= '0;
            rt_addr_q   <= '0;
            rd_q        <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            opsel_q     <= ALU_SLL;
            shamt_q     <= '0;
        end else begin
            valid_q     <= id_valid;
            reg_write_q <= id_reg_write && id_valid;
            mem_read_q  <= id_mem_read && id_valid;
            mem_write_q <= id_mem_write && id_valid;
            alu_src_q   <= id_alu_src;
            rs_addr_q   <= id_rs_addr;
            rt_addr_q   <= id_rt_addr;
            rd_q        <= id_rd_addr;
            rs_data_q   <= rs_cap;
            rt_data_q   <= rt_cap;
            imm_q       <= id_imm;
            opsel_q     <= id_opsel;
            shamt_q     <= id_shamt;
        end
    end

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .reg_addr        (rs_addr_q),
        .reg_data        (rs_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_res       (exmem_res),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_data      (memwb_data),
        .fwd_data        (rs_fwd)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .reg_addr        (rt_addr_q),
        .reg_data        (rt_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_res       (exmem_res),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_data      (memwb_data),
        .fwd_data        (rt_fwd)
    );

    // ALU-facing outputs
    always_comb begin
        alu_a         = rs_fwd;
        alu_b         = alu_src_q ? imm_q : rt_fwd;
        ex_store_data = rt_fwd;
        alu_opsel     = opsel_q;
        alu_shamt     = shamt_q;
        ex_rd         = rd_q;
        ex_valid      = valid_q;
        ex_reg_write  = reg_write_q;
        ex_mem_read   = mem_read_q;
        ex_mem_write  = mem_write_q;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the ALU.
- Latches decoded operands and control each cycle and presents ALU-ready A, B, OpSel and shamt to the execute stage.
- Resolves data hazards: forwarding from EX/MEM and MEM/WB, plus load-use stall generation with bubble insertion.
- Handles branch flush.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- id_valid  in  1  decode stage holds a valid instruction.
- id_rs_addr  in  REG_AW  source register rs.
- id_rt_addr  in  REG_AW  source register rt.
- id_rd_addr  in  REG_AW  destination register (already muxed rt/rd).
- id_rs_data  in  DATA_W  register-file read of rs.
- id_rt_data  in  DATA_W  register-file read of rt.
- id_imm  in  DATA_W  sign-extended immediate.
- id_opsel  in  6  ALU function code (funct encoding).
- id_shamt  in  5  shift amount.
- id_alu_src  in  1  1 = B operand is immediate.
- id_uses_rt  in  1  instruction reads rt.
- id_mem_read  in  1  load instruction.
- id_mem_write  in  1  store instruction.
- id_reg_write  in  1  writes a register.
- flush  in  1  taken branch; kill the instruction entering EX.
- exmem_reg_write  in  1  EX/MEM instruction writes a register.
- exmem_rd  in  REG_AW  EX/MEM destination.
- exmem_res  in  DATA_W  EX/MEM ALU result.
- memwb_reg_write  in  1  MEM/WB instruction writes a register.
- memwb_rd  in  REG_AW  MEM/WB destination.
- memwb_data  in  DATA_W  write-back data.
- stall_id  out  1  hold PC and IF/ID (load-use hazard).
- alu_a  out  DATA_W  ALU operand A (forwarded rs).
- alu_b  out  DATA_W  ALU operand B (immediate or forwarded rt).
- alu_opsel  out  6  to ALU OpSel.
- alu_shamt  out  5  to ALU shamt.
- ex_store_data  out  DATA_W  forwarded rt for stores.
- ex_rd  out  REG_AW  destination carried to EX/MEM.
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  registered control.

Behaviour:
- All registers update on rising clk. When rst_n = 0 at the edge:
  - valid and all control bits = 0.
  - data, addresses, opsel and shamt = 0.
  - Resulting outputs: alu_opsel = 0x00 (SLL) with shamt 0, which is a NOP.
- Registered latency: ID inputs appear on EX outputs one cycle later.
- Forwarding is combinational on registered values:
  - For each of rs and rt: if exmem_reg_write and exmem_rd ≠ 0 and exmem_rd == reg, select exmem_res.
  - Else if memwb_reg_write and memwb_rd ≠ 0 and memwb_rd == reg, select memwb_data.
  - Else select the registered value.
  - EX/MEM has priority. Register 0 is never forwarded.
- alu_b = imm_q when alu_src_q, else forwarded rt. ex_store_data is always forwarded rt.
- Write-through at capture: if memwb_reg_write, memwb_rd ≠ 0 and memwb_rd matches id_rs_addr/id_rt_addr in the capturing cycle, latch memwb_data instead of the register-file data.
- Load-use hazard: stall_id = ex_valid & ex_mem_read & ex_rd ≠ 0 & (ex_rd == id_rs_addr | (id_uses_rt & ex_rd == id_rt_addr)) & id_valid.
  - stall_id is combinational and is never asserted while in reset.
- On stall: insert a bubble. valid, reg_write, mem_read and mem_write are cleared, and datapath fields are don't-care (cleared). The stalled instruction is re-presented by ID next cycle.
- flush has priority over stall and over the normal load: the same bubble is inserted.
- Simultaneous stall and flush: bubble only; stall_id still reflects the hazard (upstream also flushes).
- A bubble is never forwarded, because its reg_write = 0.
- Back-to-back stalls cannot occur: after the bubble, the load is in EX/MEM and is forwarded from MEM/WB on the next cycle.
- Reset mid-stall: reset wins; stall_id drops because ex_valid = 0.

Decomposition:
- Shared package mips_pkg:
  - ALU funct constants: AND 0x24, OR 0x25, ADD 0x20, SUB 0x22, SLT 0x2A, NOR 0x27, SRL 0x02, SLL 0x00.
  - Forward-select enum {FWD_REG, FWD_EXMEM, FWD_MEMWB}.
  - DATA_W / REG_AW defaults.
- One sub-module fwd_mux: priority compare plus 3:1 select, instantiated for rs and rt.
- Hazard detect stays inline.

Test Plan:
- Reset: hold rst_n = 0 two cycles with random inputs → all ex_* = 0, alu_opsel = 0x00, stall_id = 0.
- EX/MEM forward: ADD $3 in EX/MEM (exmem_res = 0x0000_0010); next instruction SUB rs = $3 with id_rs_data = 0xDEAD → alu_a = 0x10.
- Priority: exmem_rd = memwb_rd = 5 with res 0x11 / 0x22 → alu_a = 0x11. Repeat with rd = 0 on both → register value used.
- Load-use: LW to $4 in EX, ID reads rt = $4 with id_uses_rt = 1 → stall_id = 1 for one cycle, next EX has ex_valid = 0. Following cycle alu_b = memwb_data.
- Flush with stall: assert flush and the load-use hazard together → bubble, ex_reg_write = 0, no double bubble.
- Write-through plus immediate: memwb writes $7 = 0xCAFE while ID captures rs = $7 with alu_src = 1, imm = 0xFFFF_FFFC → alu_a = 0xCAFE, alu_b = 0xFFFF_FFFC.
